// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide engine.
// Latency: none (declarations only). Backpressure: not applicable.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam int MULDIV_WIDTH = 32;
    localparam int CNT_W        = $clog2(MULDIV_WIDTH);

endpackage

// File: rtl/muldiv_step.sv
// One multiply (add-shift) or restoring-divide (shift/trial-subtract) iteration.
// Latency: combinational. Backpressure: none, the caller decides when to register.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             op,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH-1:0] rem_sub;
    logic             ge;

    always_comb begin
        sum = {1'b0, hi};
        if (lo[0]) begin
            sum = {1'b0, hi} + {1'b0, opnd};
        end
        // The true difference always fits WIDTH bits when ge holds, so the
        // low half of the subtraction is the new remainder (also for opnd == 0).
        shl     = {hi, lo[WIDTH-1]};
        ge      = (shl >= {1'b0, opnd});
        rem_sub = shl[WIDTH-1:0] - opnd;

        if (op == OP_MUL) begin
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], lo[WIDTH-1:1]};
        end else if (ge) begin
            hi_nxt = rem_sub;
            lo_nxt = {lo[WIDTH-2:0], 1'b1};
        end else begin
            hi_nxt = shl[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mul_div_seq.sv
// Iterative MULT/MULTU/DIV/DIVU feeding the HI/LO unit; signed support under MULDIV_SIGNED_EN.
// Latency: Start at edge N -> Done after edge N+WIDTH+2. Backpressure: Start ignored unless IDLE.
module mul_div_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Op,
    input  logic             Signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Upper,
    output logic [WIDTH-1:0] Lower,
    output logic             MoveToHi,
    output logic             MoveToLo,
    output logic             DivByZero
);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               op_q;
    logic               dbz_q;
    logic               is_dbz;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   acc_hi, acc_lo;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [WIDTH-1:0]   a_ld, b_ld;
    logic [2*WIDTH-1:0] fix_res;

    assign is_dbz = (Op == OP_DIV) && (B == '0);

`ifdef MULDIV_SIGNED_EN
    logic sa, sb;
    logic neg_lo, neg_hi;

    assign sa = Signed & A[WIDTH-1];
    assign sb = Signed & B[WIDTH-1];

    // Divide-by-zero keeps the raw dividend so the remainder comes out as A.
    always_comb begin
        a_ld = (sa && !is_dbz) ? -A : A;
        b_ld = sb ? -B : B;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
        end else if (state == IDLE && Start) begin
            neg_lo <= (sa ^ sb) && !is_dbz;
            neg_hi <= sa && !is_dbz;
        end
    end

    always_comb begin
        if (op_q == OP_MUL) begin
            fix_res = neg_lo ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        end else begin
            fix_res = {neg_hi ? -acc_hi : acc_hi, neg_lo ? -acc_lo : acc_lo};
        end
    end
`else
    logic unused_signed;

    assign unused_signed = Signed;
    assign a_ld          = A;
    assign b_ld          = B;
    assign fix_res       = {acc_hi, acc_lo};
`endif

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op     (op_q),
        .hi     (acc_hi),
        .lo     (acc_lo),
        .opnd   (opnd),
        .hi_nxt (step_hi),
        .lo_nxt (step_lo)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = RUN;
            RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIXUP;
            FIXUP:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        Busy = (state == RUN) || (state == FIXUP);
    end

    assign MoveToHi = Done;
    assign MoveToLo = Done;

    // Multiply: multiplicand in opnd, multiplier in acc_lo. Divide: divisor in opnd, dividend in acc_lo.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt       <= '0;
            op_q      <= OP_MUL;
            dbz_q     <= 1'b0;
            opnd      <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            Upper     <= '0;
            Lower     <= '0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        op_q   <= Op;
                        dbz_q  <= is_dbz;
                        opnd   <= (Op == OP_MUL) ? a_ld : b_ld;
                        acc_lo <= (Op == OP_MUL) ? b_ld : a_ld;
                        acc_hi <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + 1'b1;
                end
                FIXUP: begin
                    {acc_hi, acc_lo} <= fix_res;
                end
                DONE: begin
                    Upper     <= acc_hi;
                    Lower     <= acc_lo;
                    Done      <= 1'b1;
                    DivByZero <= dbz_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_seq.sv
// Bench for mul_div_seq: arithmetic reference model with per-cycle compare plus directed literal vectors.
// Expected results follow the signed feature only when MULDIV_SIGNED_EN is defined.
module tb_mul_div_seq;

    localparam int W = 32;
`ifdef MULDIV_SIGNED_EN
    localparam bit SGN_EN = 1'b1;
`else
    localparam bit SGN_EN = 1'b0;
`endif

    logic         Clk    = 1'b0;
    logic         Reset  = 1'b1;
    logic         Start  = 1'b0;
    logic         Op     = 1'b0;
    logic         Signed = 1'b0;
    logic [W-1:0] A      = '0;
    logic [W-1:0] B      = '0;
    logic         Busy, Done, MoveToHi, MoveToLo, DivByZero;
    logic [W-1:0] Upper, Lower;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int done_q[$];

    mul_div_seq #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Op        (Op),
        .Signed    (Signed),
        .A         (A),
        .B         (B),
        .Busy      (Busy),
        .Done      (Done),
        .Upper     (Upper),
        .Lower     (Lower),
        .MoveToHi  (MoveToHi),
        .MoveToLo  (MoveToLo),
        .DivByZero (DivByZero)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Returns {div_by_zero, hi, lo} from plain arithmetic.
    function automatic logic [2*W:0] predict(input logic op, input logic sgn,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
        longint       sa, sb, q, r;
        logic [63:0]  p;
        logic         s;
        s  = sgn & SGN_EN;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 1'b0) begin
            if (s) p = sa * sb;
            else   p = {32'b0, a} * {32'b0, b};
            return {1'b0, p};
        end
        if (b == '0) return {1'b1, a, {W{1'b1}}};
        if (s) begin
            q = sa / sb;
            r = sa % sb;
            return {1'b0, r[W-1:0], q[W-1:0]};
        end
        return {1'b0, a % b, a / b};
    endfunction

    // Reference timing/result model: age counts edges since acceptance.
    int           age = -1;
    logic [2*W:0] pend = '0;
    logic         exp_busy = 1'b0, exp_done = 1'b0, exp_dbz = 1'b0;
    logic [W-1:0] exp_hi = '0, exp_lo = '0;

    initial forever begin
        @(posedge Clk or negedge Reset);
        if (!Reset) begin
            age = -1; exp_busy = 0; exp_done = 0; exp_dbz = 0; exp_hi = '0; exp_lo = '0;
        end else begin
            cyc++;
            exp_done = 0;
            exp_dbz  = 0;
            if (age < 0) begin
                if (Start) begin
                    pend = predict(Op, Signed, A, B);
                    age  = 0;
                end
            end else begin
                age++;
                if (age == W + 2) begin
                    exp_done = 1;
                    exp_dbz  = pend[2*W];
                    exp_hi   = pend[2*W-1:W];
                    exp_lo   = pend[W-1:0];
                    age      = -1;
                end
            end
            exp_busy = (age >= 0) && (age <= W);
        end
    end

    initial forever begin
        @(negedge Clk);
        check("busy",  {31'b0, Busy},      {31'b0, exp_busy});
        check("done",  {31'b0, Done},      {31'b0, exp_done});
        check("mvhi",  {31'b0, MoveToHi},  {31'b0, exp_done});
        check("mvlo",  {31'b0, MoveToLo},  {31'b0, exp_done});
        check("dbz",   {31'b0, DivByZero}, {31'b0, exp_dbz});
        check("upper", Upper, exp_hi);
        check("lower", Lower, exp_lo);
        if (Done === 1'b1) done_q.push_back(cyc);
    end

    task automatic run_op(input string name, input logic op, input logic sgn,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] hi_lit, input logic [W-1:0] lo_lit, input logic dbz_lit);
        logic [2*W:0] m;
        int n;
        m = predict(op, sgn, a, b);
        check({name, "_model_hi"},  m[2*W-1:W], hi_lit);
        check({name, "_model_lo"},  m[W-1:0],   lo_lit);
        check({name, "_model_dbz"}, {31'b0, m[2*W]}, {31'b0, dbz_lit});
        @(negedge Clk);
        Op = op; Signed = sgn; A = a; B = b; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        n = 0;
        while (Done !== 1'b1 && n < W + 20) begin
            @(negedge Clk);
            n++;
        end
        check({name, "_latency"}, n, W + 2);
        check({name, "_hi"},  Upper, hi_lit);
        check({name, "_lo"},  Lower, lo_lit);
        check({name, "_dbz"}, {31'b0, DivByZero}, {31'b0, dbz_lit});
        check({name, "_strobes"}, {30'b0, MoveToHi, MoveToLo}, 32'd3);
        @(negedge Clk);
        check({name, "_pulse_end"}, {31'b0, Done}, 32'd0);
    endtask

    initial begin
        int d0, n;
        #2 Reset = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_busy",  {31'b0, Busy}, 32'd0);
        check("rst_upper", Upper, 32'd0);
        check("rst_lower", Lower, 32'd0);
        #2 Reset = 1'b1;

        run_op("multu_max2", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE, 1'b0);
        run_op("mult_neg3x7", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'h7,
               SGN_EN ? 32'hFFFF_FFFF : 32'h6, 32'hFFFF_FFEB, 1'b0);
        run_op("div_neg7by2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'h2,
               SGN_EN ? 32'hFFFF_FFFF : 32'h1, SGN_EN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC, 1'b0);
        run_op("divu_100by7", 1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op("divu_by0", 1'b1, 1'b0, 32'h123, 32'h0, 32'h123, 32'hFFFF_FFFF, 1'b1);
        run_op("div_ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
               SGN_EN ? 32'h0 : 32'h8000_0000, SGN_EN ? 32'h8000_0000 : 32'h0, 1'b0);
        run_op("div_neg_by0", 1'b1, 1'b1, 32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);
        run_op("mult_minsq", 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
        run_op("multu_maxsq", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0);
        run_op("div_7bym2", 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE,
               SGN_EN ? 32'd1 : 32'd7, SGN_EN ? 32'hFFFF_FFFD : 32'd0, 1'b0);

        // Reset asserted in the middle of RUN.
        @(negedge Clk);
        Op = 1'b0; Signed = 1'b0; A = 32'hFFFF_FFFF; B = 32'h2; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (9) @(negedge Clk);
        d0 = done_q.size();
        #2 Reset = 1'b0;
        #1;
        check("midrst_busy",  {31'b0, Busy}, 32'd0);
        check("midrst_done",  {31'b0, Done}, 32'd0);
        check("midrst_upper", Upper, 32'd0);
        check("midrst_lower", Lower, 32'd0);
        @(negedge Clk);
        #2 Reset = 1'b1;
        repeat (W + 10) @(negedge Clk);
        check("midrst_no_done", done_q.size() - d0, 32'd0);

        // Start held high across a whole operation: second op only from IDLE.
        d0 = done_q.size();
        @(negedge Clk);
        Op = 1'b0; Signed = 1'b0; A = 32'd5; B = 32'd6; Start = 1'b1;
        repeat (W + 4) @(negedge Clk);
        Start = 1'b0;
        n = 0;
        while (done_q.size() - d0 < 2 && n < 3 * W) begin
            @(negedge Clk);
            n++;
        end
        repeat (W) @(negedge Clk);
        check("b2b_count", done_q.size() - d0, 32'd2);
        if (done_q.size() - d0 >= 2)
            check("b2b_spacing", done_q[d0 + 1] - done_q[d0], W + 3);
        check("b2b_lower", Lower, 32'd30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
